// File: rtl/mov_sum_pkg.sv
// Shared sizing, FSM encoding and window-length clamp for the moving-sum sequencer.
// Pure definitions: no latency, no flow control.
package mov_sum_pkg;

    localparam int DW      = 17;
    localparam int SW      = 24;
    localparam int MAX_WIN = 64;
    localparam int AW      = $clog2(MAX_WIN);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        FILL,
        RUN,
        DRAIN
    } state_t;

    // Out-of-range requests (0 or above the buffer depth) fall back to the full buffer.
    function automatic logic [AW:0] clamp_win(input logic [AW:0] len);
        if (len == '0 || len > (AW+1)'(MAX_WIN)) begin
            return (AW+1)'(MAX_WIN);
        end
        return len;
    endfunction

endpackage

// File: rtl/mov_sum_dly_ram.sv
// Sample delay line: simple dual-port RAM, registered read, read-before-write on a shared address.
// Read data appears one clock after rd_en; no flow control, contents are never reset.
module mov_sum_dly_ram #(
    parameter int DW    = 17,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/mov_sum_ctrl.sv
// Sliding-window sequencer: feeds new/leaving sample pairs to an external accumulator.
// Sample-to-sum_valid latency 2 clocks, one sample per clock; s_ready only in FILL/RUN.
module mov_sum_ctrl
    import mov_sum_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [AW:0]   win_len,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          acc_rst,
    output logic          acc_ena,
    output logic [DW-1:0] acc_a,
    output logic [DW-1:0] acc_a_d,
    input  logic [SW-1:0] acc_sum,
    output logic          sum_valid,
    output logic          sum_full,
    output logic [SW-1:0] sum_out,
    output logic          busy
);

    // The accumulator never sees more than a full window of maximum-magnitude samples.
    localparam longint unsigned PEAK_SUM  = longint'(MAX_WIN) * ((64'd1 << DW) - 64'd1);
    localparam longint unsigned SUM_LIMIT = 64'd1 << (SW - 1);

    if (PEAK_SUM >= SUM_LIMIT) begin : g_sum_bound_check
        $error("mov_sum_ctrl: MAX_WIN full-scale samples overflow an SW-bit sum");
    end

    state_t        state;
    logic [AW:0]   win_q;
    logic [AW:0]   fill_cnt;
    logic [AW-1:0] wr_ptr;
    logic          drain_done;
    logic          run_q;
    logic          full_q;
    logic [DW-1:0] old_data;

    logic          accept;
    logic          fill_last;
    logic          ptr_wrap;

    assign s_ready   = (state == FILL) || (state == RUN);
    assign busy      = (state != IDLE);
    assign acc_rst   = rst || (state == CLR);
    assign accept    = s_valid && s_ready && !stop;
    assign fill_last = (state == FILL) && ((fill_cnt + (AW+1)'(1)) == win_q);
    assign ptr_wrap  = ({1'b0, wr_ptr} == (win_q - (AW+1)'(1)));

    // Buffer contents left over from an earlier window are hidden until the window is primed.
    assign acc_a_d   = run_q ? old_data : '0;

    mov_sum_dly_ram #(
        .DW    (DW),
        .DEPTH (MAX_WIN),
        .AW    (AW)
    ) u_dly_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_ptr),
        .wr_data (s_data),
        .rd_en   (accept),
        .rd_addr (wr_ptr),
        .rd_data (old_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            win_q      <= '0;
            fill_cnt   <= '0;
            wr_ptr     <= '0;
            drain_done <= 1'b0;
            acc_ena    <= 1'b0;
            acc_a      <= '0;
            run_q      <= 1'b0;
            full_q     <= 1'b0;
            sum_valid  <= 1'b0;
            sum_full   <= 1'b0;
            sum_out    <= '0;
        end else begin
            acc_ena   <= accept;
            run_q     <= accept && (state == RUN);
            full_q    <= accept && ((state == RUN) || fill_last);
            if (accept) begin
                acc_a  <= s_data;
                wr_ptr <= ptr_wrap ? '0 : wr_ptr + AW'(1);
            end

            sum_valid <= acc_ena;
            sum_full  <= full_q;
            if (acc_ena) begin
                sum_out <= acc_sum;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLR;
                        win_q <= clamp_win(win_len);
                    end
                end
                CLR: begin
                    state    <= FILL;
                    wr_ptr   <= '0;
                    fill_cnt <= '0;
                end
                FILL: begin
                    if (stop) begin
                        state      <= DRAIN;
                        drain_done <= 1'b0;
                    end else if (accept) begin
                        fill_cnt <= fill_cnt + (AW+1)'(1);
                        if (fill_last) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state      <= DRAIN;
                        drain_done <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= IDLE;
                    end else begin
                        drain_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mov_sum_ctrl.sv
// Directed bench for mov_sum_ctrl with a behavioural accumulator attached to its strobes.
module tb_mov_sum_ctrl;
    import mov_sum_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [AW:0]   win_len;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          acc_rst;
    logic          acc_ena;
    logic [DW-1:0] acc_a;
    logic [DW-1:0] acc_a_d;
    logic [SW-1:0] acc_sum;
    logic          sum_valid;
    logic          sum_full;
    logic [SW-1:0] sum_out;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mov_sum_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .win_len   (win_len),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .acc_rst   (acc_rst),
        .acc_ena   (acc_ena),
        .acc_a     (acc_a),
        .acc_a_d   (acc_a_d),
        .acc_sum   (acc_sum),
        .sum_valid (sum_valid),
        .sum_full  (sum_full),
        .sum_out   (sum_out),
        .busy      (busy)
    );

    // Accumulator: combinational sum = register + new - leaving, cleared by acc_rst.
    logic [SW-1:0] acc_q;
    assign acc_sum = acc_q + (acc_ena ? (SW'(acc_a) - SW'(acc_a_d)) : SW'(0));
    always_ff @(posedge clk) begin
        if (acc_rst) acc_q <= '0;
        else         acc_q <= acc_sum;
    end

    task automatic do_start(input logic [AW:0] wl, output logic clr_acc_rst, output logic clr_busy);
        @(negedge clk);
        start   = 1'b1;
        win_len = wl;
        @(negedge clk);
        start   = 1'b0;
        win_len = '0;
        clr_acc_rst = acc_rst;
        clr_busy    = busy;
    endtask

    task automatic do_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; win_len = '0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (acc_rst !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: acc_rst=%b busy=%b s_ready=%b required 1 0 0", acc_rst, busy, s_ready);
        end
        checks++;
        if (sum_valid !== 1'b0 || acc_ena !== 1'b0 || sum_out !== '0 || sum_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: sum_valid=%b acc_ena=%b sum_out=%0d sum_full=%b required zeros",
                     sum_valid, acc_ena, sum_out, sum_full);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (acc_rst !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: acc_rst=%b busy=%b required 0 0", acc_rst, busy);
        end
    endtask

    task automatic test_win4();
        int   exp_sum [6] = '{1, 3, 6, 10, 14, 18};
        logic exp_full[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic r, b;
        do_start(4, r, b);
        checks++;
        if (r !== 1'b1 || b !== 1'b1) begin
            failures++;
            $display("FAIL win4_clr: acc_rst=%b busy=%b required 1 1", r, b);
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checks++;
            if (sum_valid !== (j >= 2 && j <= 7)) begin
                failures++;
                $display("FAIL win4_valid[%0d]: got %b required %b", j, sum_valid, (j >= 2 && j <= 7));
            end
            if (j >= 2 && j <= 7) begin
                checks++;
                if (sum_out !== SW'(exp_sum[j-2]) || sum_full !== exp_full[j-2]) begin
                    failures++;
                    $display("FAIL win4_sum[%0d]: got %0d/%b required %0d/%b",
                             j - 2, sum_out, sum_full, exp_sum[j-2], exp_full[j-2]);
                end
            end
            if (j == 1) begin
                checks++;
                if (acc_ena !== 1'b1 || acc_a !== DW'(1) || acc_a_d !== '0) begin
                    failures++;
                    $display("FAIL win4_fill_pair: ena=%b a=%0d a_d=%0d required 1 1 0", acc_ena, acc_a, acc_a_d);
                end
            end
            if (j == 5) begin
                checks++;
                if (acc_ena !== 1'b1 || acc_a !== DW'(5) || acc_a_d !== DW'(1)) begin
                    failures++;
                    $display("FAIL win4_run_pair: ena=%b a=%0d a_d=%0d required 1 5 1", acc_ena, acc_a, acc_a_d);
                end
            end
            s_valid = (j < 6);
            s_data  = DW'(j + 1);
        end
        do_stop();
    endtask

    task automatic test_win1();
        int exp_sum[3] = '{7, 9, 2};
        int din    [3] = '{7, 9, 2};
        logic r, b;
        do_start(1, r, b);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            checks++;
            if (sum_valid !== (j >= 2 && j <= 4)) begin
                failures++;
                $display("FAIL win1_valid[%0d]: got %b required %b", j, sum_valid, (j >= 2 && j <= 4));
            end
            if (j >= 2 && j <= 4) begin
                checks++;
                if (sum_out !== SW'(exp_sum[j-2]) || sum_full !== 1'b1) begin
                    failures++;
                    $display("FAIL win1_sum[%0d]: got %0d/%b required %0d/1", j - 2, sum_out, sum_full, exp_sum[j-2]);
                end
            end
            if (j == 2) begin
                checks++;
                if (acc_a !== DW'(9) || acc_a_d !== DW'(7)) begin
                    failures++;
                    $display("FAIL win1_pair: a=%0d a_d=%0d required 9 7", acc_a, acc_a_d);
                end
            end
            s_valid = (j < 3);
            s_data  = (j < 3) ? DW'(din[j]) : '0;
        end
        do_stop();
    endtask

    task automatic test_random64();
        int   hist[$];
        int   exp_s[$];
        logic exp_f[$];
        int   rsum  = 0;
        int   sent  = 0;
        int   tail  = 0;
        int   nvld  = 0;
        int   es;
        logic ef;
        logic v;
        logic [DW-1:0] d;
        logic r, b;
        do_start(64, r, b);
        for (int c = 0; c < 1000 && tail < 4; c++) begin
            @(negedge clk);
            if (sum_valid === 1'b1) begin
                nvld++;
                checks++;
                if (exp_s.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra_strobe: got sum_valid with %0d %0d", sum_out, sum_full);
                end else begin
                    es = exp_s.pop_front();
                    ef = exp_f.pop_front();
                    if (sum_out !== SW'(es) || sum_full !== ef) begin
                        failures++;
                        $display("FAIL rand_sum[%0d]: got %0d/%b required %0d/%b", nvld, sum_out, sum_full, es, ef);
                    end
                end
            end
            if (sent < 200) begin
                v = ($urandom_range(0, 3) != 0);
                d = DW'($urandom);
                if (v) begin
                    hist.push_back(int'(d));
                    rsum += int'(d);
                    if (hist.size() > 64) rsum -= hist.pop_front();
                    sent++;
                    exp_s.push_back(rsum);
                    exp_f.push_back(sent >= 64);
                end
                s_valid = v;
                s_data  = d;
            end else begin
                s_valid = 1'b0;
                tail++;
            end
        end
        checks++;
        if (nvld != 200 || exp_s.size() != 0) begin
            failures++;
            $display("FAIL rand_count: got %0d strobes required 200 (%0d unmatched)", nvld, exp_s.size());
        end
        do_stop();
    endtask

    task automatic test_stop_restart();
        int exp_sum[6] = '{10, 30, 60, 100, 140, 180};
        int nvld = 0;
        logic r, b;
        do_start(4, r, b);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (sum_valid === 1'b1) nvld++;
            checks++;
            if (sum_valid !== (j >= 2 && j <= 7)) begin
                failures++;
                $display("FAIL stop_valid[%0d]: got %b required %b", j, sum_valid, (j >= 2 && j <= 7));
            end
            if (j >= 2 && j <= 7) begin
                checks++;
                if (sum_out !== SW'(exp_sum[j-2]) || sum_full !== (j >= 5)) begin
                    failures++;
                    $display("FAIL stop_sum[%0d]: got %0d/%b required %0d/%b", j - 2, sum_out, sum_full, exp_sum[j-2], (j >= 5));
                end
            end
            if (j == 7 || j == 8 || j == 9) begin
                checks++;
                if (busy !== (j != 9) || s_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stop_busy[%0d]: busy=%b s_ready=%b required %b 0", j, busy, s_ready, (j != 9));
                end
            end
            s_valid = (j <= 6);
            s_data  = DW'((j + 1) * 10);
            stop    = (j == 6);
        end
        checks++;
        if (nvld != 6) begin
            failures++;
            $display("FAIL stop_count: got %0d strobes required 6", nvld);
        end
        do_start(2, r, b);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            checks++;
            if (sum_valid !== (j == 2 || j == 3)) begin
                failures++;
                $display("FAIL restart_valid[%0d]: got %b required %b", j, sum_valid, (j == 2 || j == 3));
            end
            if (j == 2 || j == 3) begin
                checks++;
                if (sum_out !== SW'(j == 2 ? 5 : 10) || sum_full !== (j == 3)) begin
                    failures++;
                    $display("FAIL restart_sum[%0d]: got %0d/%b required %0d/%b",
                             j - 2, sum_out, sum_full, (j == 2 ? 5 : 10), (j == 3));
                end
            end
            s_valid = (j < 2);
            s_data  = DW'(5);
        end
        do_stop();
    endtask

    task automatic test_reset_mid();
        int exp_sum[4] = '{1, 3, 6, 10};
        logic r, b;
        do_start(4, r, b);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checks++;
            if (sum_valid !== (j >= 2 && j <= 5)) begin
                failures++;
                $display("FAIL rstmid_valid[%0d]: got %b required %b", j, sum_valid, (j >= 2 && j <= 5));
            end
            if (j >= 2 && j <= 5) begin
                checks++;
                if (sum_out !== SW'(exp_sum[j-2])) begin
                    failures++;
                    $display("FAIL rstmid_sum[%0d]: got %0d required %0d", j - 2, sum_out, exp_sum[j-2]);
                end
            end
            if (j == 6 || j == 8) begin
                checks++;
                if (acc_rst !== (j == 6) || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL rstmid_ctrl[%0d]: acc_rst=%b busy=%b required %b 0", j, acc_rst, busy, (j == 6));
                end
            end
            s_valid = (j < 5);
            s_data  = DW'(j + 1);
            rst     = (j == 5 || j == 6);
        end
    endtask

    task automatic test_clamp(input logic [AW:0] wl, input logic pulse_start);
        localparam int N = 72;
        int nvld = 0;
        logic r, b;
        do_start(wl, r, b);
        for (int j = 0; j < N + 4; j++) begin
            @(negedge clk);
            if (sum_valid === 1'b1) nvld++;
            if (j >= 2 && j <= N + 1) begin
                checks++;
                if (sum_valid !== 1'b1 || sum_out !== SW'(j - 1) || sum_full !== ((j - 1) >= 64)) begin
                    failures++;
                    $display("FAIL clamp_sum[w=%0d n=%0d]: got %b/%0d/%b required 1/%0d/%b",
                             wl, j - 1, sum_valid, sum_out, sum_full, j - 1, ((j - 1) >= 64));
                end
            end
            if (j == 68) begin
                checks++;
                if (busy !== 1'b1 || s_ready !== 1'b1 || acc_rst !== 1'b0) begin
                    failures++;
                    $display("FAIL clamp_run[w=%0d]: busy=%b s_ready=%b acc_rst=%b required 1 1 0",
                             wl, busy, s_ready, acc_rst);
                end
            end
            s_valid = (j < N);
            s_data  = (j < 64) ? DW'(1) : DW'(2);
            start   = pulse_start && (j == 66);
            win_len = (pulse_start && j == 66) ? (AW+1)'(4) : '0;
        end
        checks++;
        if (nvld != N) begin
            failures++;
            $display("FAIL clamp_count[w=%0d]: got %0d strobes required %0d", wl, nvld, N);
        end
        do_stop();
    endtask

    initial begin
        test_reset();
        test_win4();
        test_win1();
        test_random64();
        test_stop_restart();
        test_reset_mid();
        test_clamp(0, 1'b0);
        test_clamp(100, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
